// File: rtl/otter_dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : otter_dmem_pkg
// Brief   : Shared constants, region type and lane-merge helper for otter_dmem
// Revision: 1.0 - initial release
// ============================================================================
package otter_dmem_pkg;

  localparam logic [3:0] MTIME_LO    = 4'h0;
  localparam logic [3:0] MTIME_HI    = 4'h4;
  localparam logic [3:0] MTIMECMP_LO = 4'h8;
  localparam logic [3:0] MTIMECMP_HI = 4'hC;

  localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    REG_RAM      = 2'd0,
    REG_MMIO     = 2'd1,
    REG_UNMAPPED = 2'd2
  } region_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage
`default_nettype wire

// File: rtl/otter_mtimer.sv
`default_nettype none
// ============================================================================
// Module  : otter_mtimer
// Brief   : Prescaled 64-bit mtime / mtimecmp pair with registered compare irq
// Revision: 1.0 - initial release
// ============================================================================
module otter_mtimer
  import otter_dmem_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  offset,
  input  logic [3:0]  w_strb,
  input  logic [31:0] w_data,
  output logic [31:0] rd_data,
  output logic        irq
);

  localparam int                 c_PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(TICK_DIV - 1);

  logic [c_PRE_W-1:0] r_presc;
  logic [63:0]        r_mtime;
  logic [63:0]        r_mtimecmp;
  logic               r_irq;
  logic [63:0]        w_mtime_nxt;
  logic [63:0]        w_mtimecmp_nxt;
  logic               w_tick;

  assign w_tick = (r_presc == c_PRE_MAX);

  // A software write to an mtime half replaces the increment for the whole
  // counter this cycle; the other half simply keeps its value.
  always_comb begin
    w_mtime_nxt    = w_tick ? (r_mtime + 64'd1) : r_mtime;
    w_mtimecmp_nxt = r_mtimecmp;
    if (wr_en) begin
      case (offset)
        MTIME_LO:    w_mtime_nxt = {r_mtime[63:32], strb_merge(r_mtime[31:0], w_data, w_strb)};
        MTIME_HI:    w_mtime_nxt = {strb_merge(r_mtime[63:32], w_data, w_strb), r_mtime[31:0]};
        MTIMECMP_LO: w_mtimecmp_nxt[31:0]  = strb_merge(r_mtimecmp[31:0], w_data, w_strb);
        MTIMECMP_HI: w_mtimecmp_nxt[63:32] = strb_merge(r_mtimecmp[63:32], w_data, w_strb);
        default:     ;
      endcase
    end
  end

  always_comb begin
    rd_data = 32'h0;
    case (offset)
      MTIME_LO:    rd_data = r_mtime[31:0];
      MTIME_HI:    rd_data = r_mtime[63:32];
      MTIMECMP_LO: rd_data = r_mtimecmp[31:0];
      MTIMECMP_HI: rd_data = r_mtimecmp[63:32];
      default:     rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc    <= '0;
      r_mtime    <= 64'h0;
      r_mtimecmp <= MTIMECMP_RESET;
      r_irq      <= 1'b0;
    end else begin
      r_presc    <= w_tick ? '0 : (r_presc + 1'b1);
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_mtimecmp_nxt;
      r_irq      <= (r_mtime >= r_mtimecmp);
    end
  end

  assign irq = r_irq;

endmodule
`default_nettype wire

// File: rtl/otter_dmem.sv
`default_nettype none
// ============================================================================
// Module  : otter_dmem
// Brief   : Otter data-memory responder: byte-strobed RAM, MMIO timer, faults
// Revision: 1.0 - initial release
// ============================================================================
module otter_dmem
  import otter_dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h1100_0000,
  parameter int          TICK_DIV    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmem_r_en,
  input  logic        dmem_w_en,
  input  logic [3:0]  dmem_w_strb,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_w_data,
  output logic [31:0] dmem_r_data,
  output logic        timer_irq,
  output logic        access_fault
);

  localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_RAM_BYTES = 32'(DEPTH_WORDS * 4);

  logic [31:0]        r_mem [DEPTH_WORDS];
  logic [31:0]        r_rdata;
  logic               r_fault;
  region_e            w_region;
  logic               w_req;
  logic               w_misaligned;
  logic               w_fault;
  logic               w_ram_we;
  logic               w_mmio_we;
  logic [c_IDX_W-1:0] w_idx;
  logic [31:0]        w_mmio_rdata;

  always_comb begin
    w_region = REG_UNMAPPED;
    if (dmem_addr < c_RAM_BYTES)
      w_region = REG_RAM;
    else if (dmem_addr[31:4] == MMIO_BASE[31:4])
      w_region = REG_MMIO;
  end

  assign w_req        = dmem_r_en | dmem_w_en;
  assign w_misaligned = (dmem_addr[1:0] != 2'b00);
  assign w_fault      = w_req & (w_misaligned | (w_region == REG_UNMAPPED));
  assign w_ram_we     = dmem_w_en & ~w_fault & (w_region == REG_RAM);
  assign w_mmio_we    = dmem_w_en & ~w_fault & (w_region == REG_MMIO);
  assign w_idx        = dmem_addr[c_IDX_W+1:2];

  otter_mtimer #(
    .TICK_DIV (TICK_DIV)
  ) u_mtimer (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_mmio_we),
    .offset  (dmem_addr[3:0]),
    .w_strb  (dmem_w_strb),
    .w_data  (dmem_w_data),
    .rd_data (w_mmio_rdata),
    .irq     (timer_irq)
  );

  // Contents are not reset so the array stays mappable to block RAM.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem_w_strb[i]) r_mem[w_idx][i*8 +: 8] <= dmem_w_data[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0;
      r_fault <= 1'b0;
    end else begin
      r_fault <= w_fault;
      if (dmem_r_en) begin
        if (w_fault)
          r_rdata <= 32'h0;
        else if (w_region == REG_RAM)
          r_rdata <= r_mem[w_idx];
        else
          r_rdata <= w_mmio_rdata;
      end
    end
  end

  assign dmem_r_data  = r_rdata;
  assign access_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_otter_dmem.sv
`default_nettype none
// ============================================================================
// Module  : tb_otter_dmem
// Brief   : Self-checking bench for otter_dmem against a behavioural model
// Revision: 1.0 - initial release
// ============================================================================
module tb_otter_dmem;

  localparam int          DEPTH = 1024;
  localparam logic [31:0] MB    = 32'h1100_0000;
  localparam logic [31:0] TOPW  = 32'(DEPTH * 4 - 4);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        r_en = 1'b0;
  logic        w_en = 1'b0;
  logic [3:0]  strb = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        irq;
  logic        fault;
  logic [31:0] rdata4;
  logic        irq4;
  logic        fault4;

  otter_dmem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .dmem_r_en(r_en), .dmem_w_en(w_en),
    .dmem_w_strb(strb), .dmem_addr(addr), .dmem_w_data(wdata),
    .dmem_r_data(rdata), .timer_irq(irq), .access_fault(fault));

  // Second instance only reads mtime_lo every cycle to observe the prescaler.
  otter_dmem #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(MB), .TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .dmem_r_en(1'b1), .dmem_w_en(1'b0),
    .dmem_w_strb(4'h0), .dmem_addr(MB), .dmem_w_data(32'h0),
    .dmem_r_data(rdata4), .timer_irq(irq4), .access_fault(fault4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_mem [int];
  logic [63:0] m_mtime;
  logic [63:0] m_cmp;
  int          m_div;
  logic [31:0] e_rd;
  logic        e_fault;
  logic        e_irq;
  int          edges;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] s);
    logic [31:0] v;
    v = o;
    for (int i = 0; i < 4; i++) if (s[i]) v[i*8 +: 8] = n[i*8 +: 8];
    return v;
  endfunction

  task automatic model_reset();
    m_mtime = 64'h0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_div   = 0;
    e_rd    = 32'h0;
    e_fault = 1'b0;
    e_irq   = 1'b0;
    edges   = 0;
  endtask

  // Effect of one clock edge on the memory-mapped state, from pre-edge values.
  task automatic model_step(input bit r, input bit w, input logic [3:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    bit          is_ram, is_mmio, bad;
    logic [63:0] nt;
    is_ram  = (a < 32'(DEPTH * 4));
    is_mmio = (a[31:4] == MB[31:4]);
    bad     = (r || w) && ((a[1:0] != 2'b00) || !(is_ram || is_mmio));
    e_fault = bad;
    e_irq   = (m_mtime >= m_cmp);
    if (r) begin
      if (bad)         e_rd = 32'h0;
      else if (is_ram) e_rd = m_mem[int'(a >> 2)];
      else case (a[3:0])
        4'h0:    e_rd = m_mtime[31:0];
        4'h4:    e_rd = m_mtime[63:32];
        4'h8:    e_rd = m_cmp[31:0];
        default: e_rd = m_cmp[63:32];
      endcase
    end
    m_div = m_div + 1;
    if (m_div == 1) begin
      m_div = 0;
      nt = m_mtime + 64'd1;
    end else begin
      nt = m_mtime;
    end
    if (w && !bad) begin
      if (is_ram) m_mem[int'(a >> 2)] = lanes(m_mem[int'(a >> 2)], d, s);
      else case (a[3:0])
        4'h0:    nt = {m_mtime[63:32], lanes(m_mtime[31:0], d, s)};
        4'h4:    nt = {lanes(m_mtime[63:32], d, s), m_mtime[31:0]};
        4'h8:    m_cmp[31:0]  = lanes(m_cmp[31:0], d, s);
        default: m_cmp[63:32] = lanes(m_cmp[63:32], d, s);
      endcase
    end
    m_mtime = nt;
  endtask

  task automatic do_cycle(input bit r, input bit w, input logic [3:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    r_en = r; w_en = w; strb = s; addr = a; wdata = d;
    model_step(r, w, s, a, d);
    @(posedge clk);
    #1;
    edges++;
    chk("rdata", rdata, e_rd);
    chk("fault", 32'(fault), 32'(e_fault));
    chk("irq", 32'(irq), 32'(e_irq));
    // With a divide of 4, mtime advances once every 4 edges after release.
    chk("mtime_div4", rdata4, 32'((edges - 1) / 4));
    chk("irq_div4", 32'(irq4), 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    r_en = 1'b0; w_en = 1'b0; strb = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [3:0]  s;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk_rd;
    logic [31:0] exp_rd;
    bit          exp_fault;
  } vec_t;

  vec_t tbl [0:14];

  initial begin
    bit          found;
    logic        prev_irq;
    int          k;
    bit          r, w;
    logic [31:0] a;

    tbl = '{
      '{1'b0, 1'b1, 4'hF, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0},
      '{1'b1, 1'b0, 4'h0, 32'h10,       32'h0,        1'b1, 32'hDEADBEEF, 1'b0},
      '{1'b0, 1'b1, 4'h2, 32'h10,       32'h0000AA00, 1'b0, 32'h0,        1'b0},
      '{1'b1, 1'b0, 4'h0, 32'h10,       32'h0,        1'b1, 32'hDEADAAEF, 1'b0},
      '{1'b0, 1'b1, 4'hF, 32'h20,       32'h1,        1'b0, 32'h0,        1'b0},
      '{1'b1, 1'b1, 4'hF, 32'h20,       32'h2,        1'b1, 32'h1,        1'b0},
      '{1'b1, 1'b0, 4'h0, 32'h20,       32'h0,        1'b1, 32'h2,        1'b0},
      '{1'b1, 1'b0, 4'h0, 32'h102,      32'h0,        1'b1, 32'h0,        1'b1},
      '{1'b0, 1'b1, 4'hF, 32'h80000000, 32'h12345678, 1'b1, 32'h0,        1'b1},
      '{1'b1, 1'b0, 4'h0, 32'h10,       32'h0,        1'b1, 32'hDEADAAEF, 1'b0},
      '{1'b1, 1'b0, 4'h0, MB + 32'h8,   32'h0,        1'b1, 32'hFFFFFFFF, 1'b0},
      '{1'b0, 1'b1, 4'hF, TOPW,         32'hCAFEF00D, 1'b0, 32'h0,        1'b0},
      '{1'b1, 1'b0, 4'h0, TOPW,         32'h0,        1'b1, 32'hCAFEF00D, 1'b0},
      '{1'b1, 1'b0, 4'h0, TOPW + 32'h4, 32'h0,        1'b1, 32'h0,        1'b1},
      '{1'b0, 1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 32'h0,        1'b0}
    };

    do_reset();
    #1;
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_fault", 32'(fault), 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);

    // Give every RAM word the bench touches a known value.
    for (int i = 0; i < 32; i++) do_cycle(1'b0, 1'b1, 4'hF, 32'(i * 4), $urandom);

    for (int i = 0; i < 15; i++) begin
      do_cycle(tbl[i].r, tbl[i].w, tbl[i].s, tbl[i].a, tbl[i].d);
      if (tbl[i].chk_rd) chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_fault", i), 32'(fault), 32'(tbl[i].exp_fault));
    end

    for (int n = 0; n < 400; n++) begin
      k = $urandom_range(0, 9);
      if (k <= 5)      a = 32'($urandom_range(0, 31)) * 4;
      else if (k <= 7) a = MB + 32'($urandom_range(0, 3)) * 4;
      else if (k == 8) a = $urandom_range(0, 1) ? (32'h8000_0000 + 32'($urandom_range(0, 255)) * 4)
                                                : (MB + 32'h10);
      else             a = TOPW + 32'h4;
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      do_cycle(r, w, 4'($urandom_range(0, 15)), a, $urandom);
    end

    // Timer compare from a fresh reset.
    do_reset();
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'hC, 32'h0);
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'd20);
    found = 1'b0;
    prev_irq = irq;
    for (int i = 0; i < 40 && !found; i++) begin
      prev_irq = irq;
      do_cycle(1'b1, 1'b0, 4'h0, MB, 32'h0);
      if (rdata == 32'd20) found = 1'b1;
    end
    chk("mtime_reaches_20", 32'(found), 32'h1);
    chk("irq_low_before_match", 32'(prev_irq), 32'h0);
    chk("irq_high_at_match", 32'(irq), 32'h1);
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'hFFFF_FFFF);
    chk("irq_still_high_after_cmp_write", 32'(irq), 32'h1);
    do_cycle(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("irq_dropped", 32'(irq), 32'h0);

    // 64-bit wrap of mtime
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'h0, 32'hFFFF_FFFF);
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'h4, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b0, 4'h0, MB + 32'h0, 32'h0);
    chk("wrap_lo_before", rdata, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b0, 4'h0, MB + 32'h4, 32'h0);
    chk("wrap_hi_after", rdata, 32'h0);
    do_cycle(1'b1, 1'b0, 4'h0, MB + 32'h0, 32'h0);
    chk("wrap_lo_after", rdata, 32'h1);

    // Reset asserted between edges with all three outputs non-zero.
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'hC, 32'h0);
    do_cycle(1'b0, 1'b1, 4'hF, MB + 32'h8, 32'h0);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h10, 32'h5A5A_5A5A);
    do_cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    do_cycle(1'b0, 1'b1, 4'hF, 32'h8000_0000, 32'h0);
    chk("pre_rst_rdata", rdata, 32'h5A5A_5A5A);
    chk("pre_rst_fault", 32'(fault), 32'h1);
    chk("pre_rst_irq", 32'(irq), 32'h1);
    r_en = 1'b1; w_en = 1'b0; addr = 32'h10;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rdata", rdata, 32'h0);
    chk("async_rst_fault", 32'(fault), 32'h0);
    chk("async_rst_irq", 32'(irq), 32'h0);
    chk("async_rst_rdata4", rdata4, 32'h0);
    r_en = 1'b0; addr = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    do_cycle(1'b1, 1'b0, 4'h0, MB + 32'h0, 32'h0);
    chk("mtime_after_rst", rdata, 32'h0);
    do_cycle(1'b1, 1'b0, 4'h0, MB + 32'hC, 32'h0);
    chk("mtimecmp_hi_after_rst", rdata, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    chk("ram_kept_over_rst", rdata, 32'h5A5A_5A5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
